bin_act_packer: RTL

BIN_ACT_PACKER -- requirements
Module: bin_act_packer

---
 rtl/bin_act_packer_pkg.sv | 15 +
 rtl/bin_act_packer_threshold.sv | 15 +
 rtl/bin_act_packer.sv | 127 ++++++++++++
 3 files changed

// File: rtl/bin_act_packer_pkg.sv
// Shared binary-CNN constants: convolution window/popcount sizes, packer defaults and FSM encoding.
package bin_act_packer_pkg;

  localparam int unsigned WIN_BITS  = 4608;
  localparam int unsigned POPCNT_W  = 13;

  localparam int unsigned N_CH_DEF  = 512;
  localparam int unsigned CNT_W_DEF = POPCNT_W;

  typedef enum logic [0:0] {
    StFill,
    StHold
  } pack_state_e;

endpackage

// File: rtl/bin_act_packer_threshold.sv
// Binarised activation: popcount-vs-threshold compare with optional polarity inversion.
module bin_threshold
  import bin_act_packer_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic [CNT_W-1:0] conv_out,
  input  logic [CNT_W-1:0] thr,
  input  logic             flip,
  output logic             b
);

  assign b = (conv_out <= thr) ^ flip;

endmodule

// File: rtl/bin_act_packer.sv
// Packs one binarised activation bit per accepted beat into an N_CH-wide word with a
// one-deep output register and a HOLD state for the completed-but-blocked word.
module bin_act_packer
  import bin_act_packer_pkg::*;
#(
  parameter  int unsigned N_CH  = N_CH_DEF,
  parameter  int unsigned CNT_W = CNT_W_DEF,
  localparam int unsigned IDX_W = $clog2(N_CH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CNT_W-1:0] conv_out,
  input  logic [CNT_W-1:0] thr,
  input  logic             flip,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N_CH-1:0]  fmap_out,
  output logic [IDX_W-1:0] ch_idx
);

  pack_state_e      r_state, w_state_d;
  logic [IDX_W-1:0] r_ch_idx, w_ch_idx_d;
  logic [N_CH-1:0]  r_pack, w_pack_d;
  logic [N_CH-1:0]  r_fmap, w_fmap_d;
  logic             r_out_valid, w_out_valid_d;

  logic             w_bit;
  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_slot_free;
  logic             w_last;
  logic [N_CH-1:0]  w_pack_new;

  bin_threshold #(
    .CNT_W (CNT_W)
  ) u_thr (
    .conv_out (conv_out),
    .thr      (thr),
    .flip     (flip),
    .b        (w_bit)
  );

  // in_ready comes from state only, so it never sees out_ready combinationally.
  assign in_ready    = (r_state == StFill);
  assign w_in_fire   = in_valid && in_ready && !clr;
  assign w_out_fire  = r_out_valid && out_ready;
  assign w_slot_free = !r_out_valid || out_ready;
  assign w_last      = (r_ch_idx == IDX_W'(N_CH - 1));

  always_comb begin
    w_pack_new           = r_pack;
    w_pack_new[r_ch_idx] = w_bit;
  end

  always_comb begin
    w_state_d     = r_state;
    w_ch_idx_d    = r_ch_idx;
    w_pack_d      = r_pack;
    w_fmap_d      = r_fmap;
    w_out_valid_d = r_out_valid;

    if (w_out_fire) begin
      w_out_valid_d = 1'b0;
    end

    if (clr) begin
      // Output register is deliberately left alone; only in-flight pack data is dropped.
      w_state_d  = StFill;
      w_ch_idx_d = '0;
      w_pack_d   = '0;
    end else begin
      unique case (r_state)
        StFill: begin
          if (w_in_fire) begin
            w_pack_d = w_pack_new;
            if (w_last) begin
              w_ch_idx_d = '0;
              if (w_slot_free) begin
                w_fmap_d      = w_pack_new;
                w_out_valid_d = 1'b1;
              end else begin
                w_state_d = StHold;
              end
            end else begin
              w_ch_idx_d = r_ch_idx + IDX_W'(1);
            end
          end
        end
        StHold: begin
          if (w_out_fire) begin
            w_fmap_d      = r_pack;
            w_out_valid_d = 1'b1;
            w_state_d     = StFill;
            w_ch_idx_d    = '0;
          end
        end
        default: begin
          w_state_d = StFill;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StFill;
      r_ch_idx    <= '0;
      r_pack      <= '0;
      r_fmap      <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_ch_idx    <= w_ch_idx_d;
      r_pack      <= w_pack_d;
      r_fmap      <= w_fmap_d;
      r_out_valid <= w_out_valid_d;
    end
  end

  assign out_valid = r_out_valid;
  assign fmap_out  = r_fmap;
  assign ch_idx    = r_ch_idx;

endmodule
